instr_sequencer: RTL

Multi-cycle control sequencer for the 16-bit makina core. It fetches each instruction word over the shared single-port memory and loads the instruction register feeding the decoder. Using the decoder's class and control outputs, it steps the datapath through DECODE/EXEC/MEM/WB, gating PC update, register-file write and data-memory access. It sits between the decoder, the ALU/branch comparator and the memory port, and also counts retired instructions.

---
 rtl/instr_sequencer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer; outputs are combinational from state, mem_ready, branch_taken.
// Memory waits stretch FETCH/MEM with request signals held; retire counted in retired_cnt.
module instr_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [1:0]       instr_class,
  input  logic             dec_mem_write,
  input  logic             dec_wb_sel,
  input  logic [2:0]       jump_ctrl,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_load,
  output logic             rf_we,
  output logic             wb_sel,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             retire,
  output logic             halted,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [1:0] CLS_MEM  = 2'b00;
  localparam logic [1:0] CLS_ALU  = 2'b01;
  localparam logic [1:0] CLS_JUMP = 2'b10;
  localparam logic [1:0] CLS_ILL  = 2'b11;

  state_t           r_state;
  state_t           w_next;
  logic             r_halted;
  logic [CNT_W-1:0] r_cnt;
  logic             w_retire;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_halted <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == S_HALT) r_halted <= 1'b1;
      if (w_retire) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next   = r_state;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_load  = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    pc_sel   = 1'b0;
    w_retire = 1'b0;
    case (r_state)
      S_IDLE: if (run) w_next = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: w_next = (instr_class == CLS_ILL) ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (instr_class)
          CLS_ALU: w_next = S_WB;
          CLS_MEM: w_next = S_MEM;
          CLS_JUMP: begin
            w_retire = 1'b1;
            pc_sel   = (jump_ctrl != 3'b111) && branch_taken;
          end
          default: w_next = S_HALT;
        endcase
      end
      S_MEM: begin
        // request signals depend only on state and IR, so they stay flat across waits
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = dec_mem_write;
        if (mem_ready) begin
          if (dec_mem_write) w_retire = 1'b1;
          else               w_next   = S_WB;
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        wb_sel   = dec_wb_sel;
        w_retire = 1'b1;
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
    if (w_retire) w_next = run ? S_FETCH : S_IDLE;
  end

  assign pc_en       = w_retire;
  assign retire      = w_retire;
  assign halted      = r_halted;
  assign retired_cnt = r_cnt;
  assign state       = r_state;

endmodule
